// File: rtl/layer_argmax.sv
// layer_argmax: sequential arg-max over a packed vector of IEEE-754 singles.
//   Accepts one vector per transaction (valid/ready), scans one element per
//   clock, and presents the index and value of the largest non-NaN element.
//   NaNs are skipped; ties keep the lower index; +0 and -0 compare equal.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/in     input vector handshake, element i = in[32*i +: 32]
//   out_valid/out_ready      result handshake
//   out_index, out_value     index and value of the maximum element
//   out_all_nan              every element was NaN (index 0, value = element 0)
module layer_argmax #(
  parameter int unsigned VLEN  = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*VLEN-1:0] in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [31:0]       out_value,
  output logic              out_all_nan
);

  localparam int unsigned CNT_W = (VLEN > 1) ? $clog2(VLEN) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_nxt;
  logic [32*VLEN-1:0] vec_q;
  logic [CNT_W-1:0]   cnt;
  logic               have_best;
  logic [31:0]        best;
  logic [IDX_W-1:0]   best_idx;

  logic               elem_nan, take, last;
  logic [31:0]        elem, nxt_best;
  logic [IDX_W-1:0]   nxt_idx;
  logic               nxt_have;

  // a > b for non-NaN singles, with +0 == -0.
  function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31])
      return !a[31] && !((a[30:0] == '0) && (b[30:0] == '0));
    else if (!a[31])
      return a[30:0] > b[30:0];
    else
      return a[30:0] < b[30:0];
  endfunction

  // The vector is shifted down each scan cycle, so the current element is
  // always the low word and no wide read mux is needed.
  always_comb begin
    elem     = vec_q[31:0];
    elem_nan = (&elem[30:23]) && (|elem[22:0]);
    take     = !elem_nan && (!have_best || fgt(elem, best));
    last     = (cnt == CNT_W'(VLEN - 1));
    nxt_best = take ? elem : best;
    nxt_idx  = take ? IDX_W'(cnt) : best_idx;
    nxt_have = have_best | take;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = SCAN;
      SCAN: if (last)     state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE) && !rst;
  end

  // Datapath. best is preloaded with element 0 while have_best stays clear,
  // so an all-NaN vector naturally reports index 0 and element 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      cnt         <= '0;
      have_best   <= 1'b0;
      best        <= '0;
      best_idx    <= '0;
      out_index   <= '0;
      out_value   <= '0;
      out_all_nan <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          vec_q     <= in;
          cnt       <= '0;
          have_best <= 1'b0;
          best      <= in[31:0];
          best_idx  <= '0;
        end
        SCAN: begin
          vec_q     <= vec_q >> 32;
          cnt       <= cnt + 1'b1;
          have_best <= nxt_have;
          best      <= nxt_best;
          best_idx  <= nxt_idx;
          if (last) begin
            out_index   <= nxt_idx;
            out_value   <= nxt_best;
            out_all_nan <= !nxt_have;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_argmax.sv
module tb_layer_argmax;

  localparam int VL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_index;
  logic [31:0]   out_value;
  logic          out_all_nan;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_argmax #(.VLEN(VL), .IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value), .out_all_nan(out_all_nan)
  );

  function automatic logic [127:0] pack4(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Reference model: map each non-NaN float to a signed integer whose order
  // matches numeric order (both zeros map to 0), then take the first maximum.
  function automatic longint fkey(input logic [31:0] f);
    return f[31] ? -longint'({1'b0, f[30:0]}) : longint'({1'b0, f[30:0]});
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 0);
  endfunction

  task automatic model(input logic [127:0] v, output int idx, output logic [31:0] val,
                       output logic an);
    logic [31:0] e[VL];
    longint bk;
    for (int i = 0; i < VL; i++) e[i] = v[32*i +: 32];
    idx = -1;
    bk = 0;
    for (int i = 0; i < VL; i++)
      if (!is_nan(e[i]) && (idx < 0 || fkey(e[i]) > bk)) begin
        idx = i;
        bk = fkey(e[i]);
      end
    an = (idx < 0);
    if (idx < 0) idx = 0;
    val = e[idx];
  endtask

  // Drive one vector, return posedges from accept to out_valid (-1 if never accepted).
  task automatic send(input logic [127:0] v, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec = v;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_vec = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Full transaction checked against the model.
  task automatic run_vec(input string name, input logic [127:0] v);
    int lat, eidx;
    logic [31:0] evl;
    logic ean;
    model(v, eidx, evl, ean);
    send(v, lat);
    checks++;
    if (lat !== VL) begin failures++; $display("FAIL %s latency: got %0d expected %0d", name, lat, VL); end
    checks++;
    if (out_index !== 2'(eidx)) begin failures++; $display("FAIL %s index: got %0d expected %0d", name, out_index, eidx); end
    checks++;
    if (out_value !== evl) begin failures++; $display("FAIL %s value: got %h expected %h", name, out_value, evl); end
    checks++;
    if (out_all_nan !== ean) begin failures++; $display("FAIL %s all_nan: got %b expected %b", name, out_all_nan, ean); end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s post-handshake: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_index, out_value, out_all_nan} !== 36'd0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b idx=%0d val=%h an=%b expected all 0",
               in_ready, out_valid, out_index, out_value, out_all_nan);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    run_vec("basic",   pack4(32'h40200000, 32'hC0000000, 32'h40400000, 32'h3F800000));
    run_vec("tie",     pack4(32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000));
    run_vec("zeros",   pack4(32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000));
    run_vec("allneg",  pack4(32'hC0A00000, 32'hBF800000, 32'hC0400000, 32'hC0000000));
    run_vec("inf",     pack4(32'hC0A00000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000));
    run_vec("denorm",  pack4(32'h80000001, 32'h00000001, 32'h00000000, 32'h807FFFFF));
  endtask

  task automatic test_nan();
    run_vec("nan_mix", pack4(32'h7FC00000, 32'h3F800000, 32'hFFC00000, 32'h40000000));
    run_vec("nan_all", pack4(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000));
    run_vec("nan_first_neg", pack4(32'hFF800001, 32'hFF800000, 32'h7FFFFFFF, 32'hC0000000));
  endtask

  task automatic test_backpressure();
    int lat;
    logic [1:0] hi;
    logic [31:0] hv;
    send(pack4(32'h3F800000, 32'h41200000, 32'hC1200000, 32'h40000000), lat);
    checks++;
    if (lat !== VL || out_index !== 2'd1 || out_value !== 32'h41200000) begin
      failures++;
      $display("FAIL bp_result: lat=%0d idx=%0d val=%h expected %0d/1/41200000", lat, out_index, out_value, VL);
    end
    hi = out_index; hv = out_value;
    in_valid = 1'b1;
    in_vec = pack4(32'h7F800000, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== hi || out_value !== hv) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b idx=%0d val=%h expected 1/0/%0d/%h",
                 c, out_valid, in_ready, out_index, out_value, hi, hv);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    run_vec("b2b_0", pack4(32'h40400000, 32'h40400001, 32'h0, 32'h80000000));
    run_vec("b2b_1", pack4(32'hBF000000, 32'hBF000000, 32'hBF000001, 32'hFF800000));
  endtask

  task automatic test_reset_mid_scan();
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_low: got %b expected 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_index, out_value, out_all_nan} !== 35'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: valid=%b idx=%0d val=%h an=%b expected 0", out_valid, out_index, out_value, out_all_nan);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    n = 0;
    for (int c = 0; c < VL + 3; c++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL rst_mid_no_pulse: got %0d valid cycles expected 0", n); end
    run_vec("after_rst", pack4(32'hC0000000, 32'h3F000000, 32'h7FC00000, 32'h3E800000));
  endtask

  function automatic logic [31:0] rand_elem(input logic [31:0] prev);
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 7))
      0: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      1: return {s, 31'd0};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'($urandom_range(126, 129)), 23'($urandom_range(0, 3)) << 20};
      4: return prev;
      5: return {s, 8'd0, 23'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [127:0] v;
    logic [31:0] e;
    for (int t = 0; t < 40; t++) begin
      e = $urandom;
      for (int i = 0; i < VL; i++) begin
        e = (t % 9 == 8) ? {1'($urandom), 8'hFF, 23'($urandom_range(1, 1000))} : rand_elem(e);
        v[32*i +: 32] = e;
      end
      run_vec($sformatf("rand%0d", t), v);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_nan();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
